// File: rtl/dfe_train_tx_if.sv
// Symbol-path bundle for the DFE training transmitter: payload bits in, mapped
// symbols out. The transmitter owns the master side.
interface dfe_train_tx_if;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic [15:0] x_out;
    logic        x_valid;
    logic        train_out;
    logic        ref_bit;

    modport master (
        input  bit_in, bit_valid,
        output bit_ready, x_out, x_valid, train_out, ref_bit
    );

    modport slave (
        output bit_in, bit_valid,
        input  bit_ready, x_out, x_valid, train_out, ref_bit
    );
endinterface

// File: rtl/dfe_train_tx.sv
// Frame generator for equalizer training: PN training preamble, payload symbols
// taken from a bit stream, then an idle gap. All outputs are registered.
module dfe_train_tx #(
    parameter int         TRAIN_LEN = 64,
    parameter int         DATA_LEN  = 256,
    parameter int         GAP_LEN   = 4,
    parameter logic [6:0] PN_SEED   = 7'h7F
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic underrun,
    dfe_train_tx_if.master bus
);

    typedef enum logic [1:0] {IDLE, TRAIN, DATA, GAP} state_t;

    localparam logic [15:0] LEVEL_POS  = 16'h7FFF;
    localparam logic [15:0] LEVEL_NEG  = 16'h8000;
    localparam logic [9:0]  TRAIN_LAST = 10'(TRAIN_LEN - 1);
    localparam logic [9:0]  DATA_LAST  = 10'(DATA_LEN - 1);
    localparam logic [9:0]  GAP_LAST   = 10'(GAP_LEN - 1);

    state_t     state;
    logic [9:0] cnt;
    logic [6:0] lfsr;

    function automatic logic [15:0] map_bit(input logic b);
        return b ? LEVEL_NEG : LEVEL_POS;
    endfunction

    // The payload source sees ready from state alone, so it can present a bit
    // in the same cycle without a round trip through a register.
    assign bus.bit_ready = (state == DATA) && !reset;

    // NOTE: non-blocking assignments throughout, so every register here sees
    // the pre-edge value of every other one regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            lfsr          <= PN_SEED;
            busy          <= 1'b0;
            underrun      <= 1'b0;
            bus.x_out     <= '0;
            bus.x_valid   <= 1'b0;
            bus.train_out <= 1'b0;
            bus.ref_bit   <= 1'b0;
        end else begin
            // Idle symbol by default; TRAIN and DATA override below.
            bus.x_out     <= '0;
            bus.x_valid   <= 1'b0;
            bus.train_out <= 1'b0;
            bus.ref_bit   <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= TRAIN;
                        cnt      <= '0;
                        lfsr     <= PN_SEED;
                        busy     <= 1'b1;
                        underrun <= 1'b0;
                    end
                end

                TRAIN: begin
                    bus.x_out     <= map_bit(lfsr[6]);
                    bus.x_valid   <= 1'b1;
                    bus.train_out <= 1'b1;
                    bus.ref_bit   <= lfsr[6];
                    // x^7 + x^6 + 1, output taken from the MSB before the shift
                    lfsr          <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
                    if (cnt == TRAIN_LAST) begin
                        state <= DATA;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end

                DATA: begin
                    // A missing bit still consumes its slot so frame timing never slips.
                    bus.x_valid <= 1'b1;
                    if (bus.bit_valid) begin
                        bus.x_out <= map_bit(bus.bit_in);
                    end else begin
                        underrun <= 1'b1;
                    end
                    if (cnt == DATA_LAST) begin
                        state <= GAP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end

                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dfe_train_tx.sv
// Randomized frame-level bench for dfe_train_tx against a cycle-indexed model
// built from the frame layout and the PN recurrence.
module tb_dfe_train_tx;

    localparam int T = 64;
    localparam int D = 256;
    localparam int G = 4;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic start_pn;
    logic busy, underrun, busy_pn, underrun_pn;

    dfe_train_tx_if bus ();
    dfe_train_tx_if bus_pn ();

    dfe_train_tx dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .underrun (underrun),
        .bus      (bus.master)
    );

    dfe_train_tx #(.TRAIN_LEN(127), .DATA_LEN(1), .GAP_LEN(1)) dut_pn (
        .clk      (clk),
        .reset    (reset),
        .start    (start_pn),
        .busy     (busy_pn),
        .underrun (underrun_pn),
        .bus      (bus_pn.master)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    logic pn      [0:1023];
    logic pay_bit [0:D-1];
    logic pay_vld [0:D-1];
    logic exp_und;

    function automatic logic [15:0] level(input logic b);
        return b ? 16'h8000 : 16'h7FFF;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one frame from IDLE; k counts edges after the edge that samples start.
    task automatic run_frame(input string tag, input bit alt, input int drop_at,
                             input int drop_n, input bit stray, input int abort_at);
        int          hs;
        int          nvalid;
        logic [15:0] ex_x;
        logic        ex_v, ex_t, ex_r, ex_b, ex_rdy;
        hs     = 0;
        nvalid = 0;
        for (int j = 0; j < D; j++) begin
            pay_bit[j] = alt ? 1'(j % 2) : 1'($urandom_range(0, 1));
            pay_vld[j] = !(j >= drop_at && j < drop_at + drop_n);
            if (pay_vld[j]) nvalid++;
        end
        start = 1'b1;
        tick();
        start   = 1'b0;
        exp_und = 1'b0;
        for (int k = 0; k <= T + D + G; k++) begin
            ex_b   = (k < T + D + G);
            ex_rdy = (k >= T && k < T + D);
            ex_x = '0; ex_v = 1'b0; ex_t = 1'b0; ex_r = 1'b0;
            if (k >= 1 && k <= T) begin
                ex_v = 1'b1; ex_t = 1'b1; ex_r = pn[k-1]; ex_x = level(pn[k-1]);
            end else if (k >= T + 1 && k <= T + D) begin
                ex_v = 1'b1;
                if (pay_vld[k-T-1]) ex_x = level(pay_bit[k-T-1]);
                else exp_und = 1'b1;
            end
            tests++;
            if ({busy, bus.x_valid, bus.train_out, bus.ref_bit, bus.x_out, bus.bit_ready, underrun}
                !== {ex_b, ex_v, ex_t, ex_r, ex_x, ex_rdy, exp_und}) begin
                fails++;
                $display("FAIL %s k=%0d got busy=%b xv=%b tr=%b rb=%b x=%h rdy=%b und=%b exp busy=%b xv=%b tr=%b rb=%b x=%h rdy=%b und=%b",
                         tag, k, busy, bus.x_valid, bus.train_out, bus.ref_bit, bus.x_out,
                         bus.bit_ready, underrun, ex_b, ex_v, ex_t, ex_r, ex_x, ex_rdy, exp_und);
            end
            if (k == abort_at) begin
                reset = 1'b1;
                start = 1'b1;
                bus.bit_valid = 1'b1;
                #1;
                tests++;
                if (bus.bit_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL %s_ready_in_reset got %b exp 0", tag, bus.bit_ready);
                end
                tick();
                reset = 1'b0;
                start = 1'b0;
                exp_und = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    tests++;
                    if ({busy, bus.x_valid, bus.train_out, bus.ref_bit, bus.x_out, bus.bit_ready, underrun} !== 22'd0) begin
                        fails++;
                        $display("FAIL %s_after_reset c=%0d got busy=%b xv=%b tr=%b rb=%b x=%h rdy=%b und=%b exp all 0",
                                 tag, c, busy, bus.x_valid, bus.train_out, bus.ref_bit, bus.x_out,
                                 bus.bit_ready, underrun);
                    end
                    tick();
                end
                return;
            end
            if (k >= T && k < T + D) begin
                bus.bit_valid = pay_vld[k-T];
                bus.bit_in    = pay_bit[k-T];
                if (pay_vld[k-T] && bus.bit_ready) hs++;
            end else begin
                bus.bit_valid = 1'($urandom_range(0, 1));
                bus.bit_in    = 1'($urandom_range(0, 1));
            end
            // Stray starts while busy, including the edge that returns to IDLE.
            start = stray && ((k == T + D + G - 1) ||
                              (k < T + D + G - 1 && $urandom_range(0, 7) == 0));
            tick();
        end
        start = 1'b0;
        bus.bit_valid = 1'b0;
        tests++;
        if (hs !== nvalid) begin
            fails++;
            $display("FAIL %s_handshakes got %0d exp %0d", tag, hs, nvalid);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
        bus.bit_valid = 1'b1;
        tick();
        tick();
        tests++;
        if ({busy, bus.x_valid, bus.train_out, bus.ref_bit, bus.x_out, bus.bit_ready, underrun} !== 22'd0) begin
            fails++;
            $display("FAIL reset_state got busy=%b xv=%b tr=%b rb=%b x=%h rdy=%b und=%b exp all 0",
                     busy, bus.x_valid, bus.train_out, bus.ref_bit, bus.x_out, bus.bit_ready, underrun);
        end
        reset = 1'b0;
        start = 1'b0;
        bus.bit_valid = 1'b0;
        tick();
        tick();
        tests++;
        if ({busy, bus.x_valid} !== 2'b00) begin
            fails++;
            $display("FAIL reset_start_dropped got busy=%b xv=%b exp 0 0", busy, bus.x_valid);
        end
    endtask

    task automatic test_training_start;
        run_frame("train_start", 1'b0, D, 0, 1'b0, -1);
    endtask

    task automatic test_alternating;
        run_frame("alternating", 1'b1, D, 0, 1'b0, -1);
    endtask

    task automatic test_underrun;
        run_frame("underrun", 1'b0, int'($urandom_range(0, D - 3)), 3, 1'b0, -1);
        repeat (3) tick();
        tests++;
        if (underrun !== 1'b1) begin
            fails++;
            $display("FAIL underrun_sticky_idle got %b exp 1", underrun);
        end
        run_frame("underrun_clear", 1'b0, D, 0, 1'b0, -1);
    endtask

    task automatic test_stray_start;
        run_frame("stray_start", 1'b0, D, 0, 1'b1, -1);
        run_frame("restart_after_idle", 1'b0, D, 0, 1'b0, -1);
    endtask

    task automatic test_abort;
        run_frame("abort", 1'b0, D, 0, 1'b0, T + 100);
        run_frame("after_abort", 1'b0, D, 0, 1'b0, -1);
    endtask

    task automatic test_pn127;
        int n;
        int ones;
        n    = 0;
        ones = 0;
        bus_pn.bit_valid = 1'b1;
        bus_pn.bit_in    = 1'b0;
        start_pn = 1'b1;
        tick();
        start_pn = 1'b0;
        for (int k = 0; k < 140; k++) begin
            if (bus_pn.x_valid && bus_pn.train_out && n < 1024) begin
                tests++;
                if (bus_pn.ref_bit !== pn[n] || bus_pn.x_out !== level(pn[n])) begin
                    fails++;
                    $display("FAIL pn127 n=%0d got rb=%b x=%h exp rb=%b x=%h",
                             n, bus_pn.ref_bit, bus_pn.x_out, pn[n], level(pn[n]));
                end
                if (bus_pn.ref_bit === 1'b1) ones++;
                n++;
            end
            tick();
        end
        tests++;
        if (n !== 127) begin
            fails++;
            $display("FAIL pn127_length got %0d exp 127", n);
        end
        tests++;
        if (ones !== 64 || (n - ones) !== 63) begin
            fails++;
            $display("FAIL pn127_balance got ones=%0d zeros=%0d exp 64 63", ones, n - ones);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Output sequence of x^7+x^6+1 from an all-ones seed: o[i] = o[i-7] ^ o[i-6].
        for (int i = 0; i < 7; i++) pn[i] = 1'b1;
        for (int i = 7; i < 1024; i++) pn[i] = pn[i-7] ^ pn[i-6];
        reset = 1'b1;
        start = 1'b0;
        start_pn = 1'b0;
        bus.bit_in = 1'b0;
        bus.bit_valid = 1'b0;
        bus_pn.bit_in = 1'b0;
        bus_pn.bit_valid = 1'b0;
        exp_und = 1'b0;
        test_reset();
        test_training_start();
        test_alternating();
        test_underrun();
        test_stray_start();
        test_abort();
        test_pn127();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dfe_train_tx.md
DFE_TRAIN_TX -- requirements
Module: dfe_train_tx

Interface
REQ-001 Parameter TRAIN_LEN, default 64, training symbols per frame (range 2..1023).
REQ-002 Parameter DATA_LEN, default 256, payload symbols per frame (range 1..1023).
REQ-003 Parameter GAP_LEN, default 4, idle cycles after the payload (range 1..15).
REQ-004 Parameter PN_SEED, default 7'h7F, LFSR seed (nonzero).
REQ-005 clk  input  1  single clock, all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle frame request, honoured only in IDLE.
REQ-008 bit_in  input  1  payload bit: 0 means +1, 1 means -1.
REQ-009 bit_valid  input  1  bit_in is valid.
REQ-010 bit_ready  output  1  block accepts bit_in this cycle.
REQ-011 x_out  output  16  two's-complement symbol sample.
REQ-012 x_valid  output  1  x_out carries a symbol this cycle.
REQ-013 train_out  output  1  current x_out is a training symbol.
REQ-014 ref_bit  output  1  known decision bit for the current training symbol (0 means +1, 1 means -1), 0 outside training.
REQ-015 busy  output  1  FSM is not in IDLE.
REQ-016 underrun  output  1  sticky flag: a payload slot had no valid bit.

Function
REQ-017 FSM states: IDLE, TRAIN, DATA, GAP; state, counter and all outputs are registered.
REQ-018 Transition IDLE->TRAIN occurs on the edge sampling start=1; the LFSR is loaded with PN_SEED and the counter is cleared on the same edge.
REQ-019 TRAIN lasts exactly TRAIN_LEN cycles, then DATA lasts exactly DATA_LEN cycles, then GAP lasts exactly GAP_LEN cycles, then the FSM returns to IDLE.
REQ-020 The symbol counter is 10 bits, clears on every state change and never wraps inside a state.
REQ-021 LFSR: 7 bits, polynomial x^7+x^6+1, shifts once per TRAIN cycle; the training bit is lfsr[6] before the shift.
REQ-022 Mapping: bit 0 -> 16'h7FFF, bit 1 -> 16'h8000, matching the equalizer slicer levels.
REQ-023 Latency is 1 cycle: a symbol decided in cycle n appears on x_out/x_valid/train_out/ref_bit in cycle n+1.
REQ-024 In TRAIN, x_valid=1, train_out=1, and ref_bit equals the mapped training bit.
REQ-025 bit_ready = 1 only while in DATA, combinationally from state; the handshake completes when bit_valid and bit_ready are both 1.
REQ-026 In a DATA cycle with a handshake, x_out is the mapped bit_in, x_valid=1, and train_out=0.
REQ-027 In a DATA cycle without bit_valid: x_out=16'h0000, x_valid=1, underrun set to 1, and the slot is still consumed, so frame length stays fixed.
REQ-028 In GAP and IDLE: x_out=0, x_valid=0, train_out=0, ref_bit=0.
REQ-029 start while busy=1 is ignored; start on the cycle the FSM enters IDLE from GAP is not honoured, and start in the following cycle is.
REQ-030 underrun clears only on reset or on an accepted start.
REQ-031 busy=1 in TRAIN, DATA and GAP, and busy=0 in IDLE.

Reset
REQ-032 When reset=1 at a clock edge, the following take effect on that edge, regardless of state including mid-frame: FSM=IDLE, counter=0, LFSR=PN_SEED, x_out=0, x_valid=0, train_out=0, ref_bit=0, busy=0, underrun=0.
REQ-033 When reset=1, bit_ready=0; reset has priority over start, and start asserted with reset is dropped.

Verification
REQ-034 Reset, one-cycle start pulse with defaults -> busy rises on the next edge; 64 training symbols appear starting 1 cycle later; the first three are 16'h8000, 16'h8000, 16'h8000 (seed 7'h7F, bits 1,1,1); ref_bit tracks them.
REQ-035 Full frame with bit_valid held 1 and alternating bits 0,1 -> 256 payload samples 7FFF, 8000, ...; exactly 256 handshakes; then 4 cycles with x_valid=0; busy=0 after 64+256+4 cycles.
REQ-036 Drop bit_valid for 3 payload cycles -> three 16'h0000 samples with x_valid=1; underrun=1 and held through GAP; frame length unchanged; next start clears underrun.
REQ-037 Pulse start during TRAIN and DATA -> no effect on state, counter or LFSR sequence; start one cycle after returning to IDLE -> new frame with the training sequence restarting from the seed.
REQ-038 Assert reset at payload symbol 100 -> all outputs at reset values on the next edge, bit_ready=0, no further samples; a following start produces a full, correct frame.
REQ-039 Run 127 consecutive training symbols (TRAIN_LEN=127) -> bit sequence period 127, with 64 ones and 63 zeros.
